// File: rtl/decode_pkg.sv
// Shared types for the decode/issue stage: control bundle, queue entry, opcodes and enums.
// The M-extension decode is enabled by defining DECODE_M_EXT_EN.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Widest PC the queue entry can carry; the top truncates to its XLEN.
    localparam int XLEN_MAX = 32;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_LUI    = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I  = 2'b00,
        IMM_S  = 2'b01,
        IMM_B  = 2'b10,
        IMM_UJ = 2'b11
    } imm_sel_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_width_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       auipc_sel;
        logic       mem_unsigned;
        logic       illegal;
        logic       md;
        alu_op_e    alu_op;
        imm_sel_e   imm_sel;
        mem_width_e mem_width;
    } ctrl_t;

    typedef struct packed {
        ctrl_t               ctrl;
        logic [XLEN_MAX-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [2:0]          funct3;
    } entry_t;

    // funct7 legality shared by R-type and OP-IMM shifts: only SUB/SRA(I) may use the alternate encoding.
    function automatic logic funct7_ok(input logic [6:0] funct7, input logic [2:0] funct3);
        return (funct7 == FUNCT7_BASE) ||
               ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder producing the control bundle, register fields and illegal flag.
// With DECODE_M_EXT_EN defined, R-type funct7=0000001 decodes as a legal M op (md=1).
module instr_decoder
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [2:0]  funct3
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       bad;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    always_comb begin
        ctrl = '0;
        bad  = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == FUNCT7_MULDIV) begin
`ifdef DECODE_M_EXT_EN
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_FUNCT;
                    ctrl.md        = 1'b1;
`else
                    bad = 1'b1;
`endif
                end else if (funct7_ok(funct7, funct3)) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_FUNCT;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (((funct3 == 3'b001) || (funct3 == 3'b101)) && !funct7_ok(funct7, funct3)) begin
                    bad = 1'b1;
                end else begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.alu_op    = ALU_FUNCT;
                end
            end
            OPC_LOAD: begin
                if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)) begin
                    bad = 1'b1;
                end else begin
                    ctrl.reg_write    = 1'b1;
                    ctrl.mem_to_reg   = 1'b1;
                    ctrl.mem_read     = 1'b1;
                    ctrl.alu_src      = 1'b1;
                    ctrl.imm_sel      = IMM_I;
                    ctrl.mem_width    = mem_width_e'(funct3[1:0]);
                    ctrl.mem_unsigned = funct3[2];
                end
            end
            OPC_STORE: begin
                if (funct3 > 3'b010) begin
                    bad = 1'b1;
                end else begin
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.imm_sel   = IMM_S;
                    ctrl.mem_width = mem_width_e'(funct3[1:0]);
                end
            end
            OPC_BRANCH: begin
                if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
                    bad = 1'b1;
                end else begin
                    ctrl.branch  = 1'b1;
                    ctrl.alu_op  = ALU_BRANCH;
                    ctrl.imm_sel = IMM_B;
                end
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.imm_sel   = IMM_UJ;
            end
            OPC_JALR: begin
                if (funct3 != 3'b000) begin
                    bad = 1'b1;
                end else begin
                    ctrl.reg_write = 1'b1;
                    ctrl.jump      = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.imm_sel   = IMM_I;
                end
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_LUI;
                ctrl.imm_sel   = IMM_UJ;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_sel   = IMM_UJ;
                ctrl.auipc_sel = 1'b1;
            end
            OPC_FENCE: begin
                ctrl = '0;
            end
            default: begin
                bad = 1'b1;
            end
        endcase

        // Trap entries must not trigger any side effect downstream.
        if (bad) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_issue_queue.sv
// Decode-and-issue stage: decodes at push and holds decoded entries in a DEPTH-entry queue.
// DECODE_M_EXT_EN enables M-op decode plus the multi-cycle head hold and md_busy.
module decode_issue_queue
    import decode_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 4
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output ctrl_t           out_ctrl,
    output logic            md_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    entry_t           push_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             in_ready_q;
    logic             push;
    logic             pop;

    instr_decoder u_decoder (
        .instr  (in_instr),
        .ctrl   (push_entry.ctrl),
        .rs1    (push_entry.rs1),
        .rs2    (push_entry.rs2),
        .rd     (push_entry.rd),
        .funct3 (push_entry.funct3)
    );

    assign push_entry.pc = XLEN_MAX'(in_pc);

    assign push       = in_valid && in_ready_q;
    assign pop        = out_valid && out_ready;
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign head       = mem[rd_ptr];

    // Flush wins over push and pop; in_ready is registered so it never depends on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count      <= count_next;
            in_ready_q <= (count_next != CNT_W'(DEPTH));
        end
    end

`ifdef DECODE_M_EXT_EN
    localparam int HOLD_W = $clog2(MD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MD_CYCLES - 1);

    logic [HOLD_W-1:0] hold;
    logic              new_head;
    logic              new_head_md;

    // A new head appears either behind a popped entry or as a push into an empty queue.
    always_comb begin
        new_head    = 1'b0;
        new_head_md = 1'b0;
        if (pop) begin
            if (count > CNT_W'(1)) begin
                new_head    = 1'b1;
                new_head_md = mem[rd_ptr_inc].ctrl.md;
            end else if (push) begin
                new_head    = 1'b1;
                new_head_md = push_entry.ctrl.md;
            end
        end else if (push && (count == '0)) begin
            new_head    = 1'b1;
            new_head_md = push_entry.ctrl.md;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hold <= '0;
        end else if (new_head) begin
            hold <= new_head_md ? HOLD_INIT : '0;
        end else if (hold != '0) begin
            hold <= hold - HOLD_W'(1);
        end
    end

    assign out_valid = (count != '0) && (hold == '0);
    assign md_busy   = head.ctrl.md && (hold != '0);
`else
    assign out_valid = (count != '0);
    assign md_busy   = 1'b0;
`endif

    assign in_ready   = in_ready_q;
    assign out_pc     = head.pc[XLEN-1:0];
    assign out_rs1    = head.rs1;
    assign out_rs2    = head.rs2;
    assign out_rd     = head.rd;
    assign out_funct3 = head.funct3;
    assign out_ctrl   = head.ctrl;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed self-checking bench for decode_issue_queue (DEPTH=2, MD_CYCLES=4).
// Expectations for M ops follow whether DECODE_M_EXT_EN is defined for the build.
module tb_decode_issue_queue;
    import decode_pkg::*;

    localparam int DEPTH     = 2;
    localparam int XLEN      = 32;
    localparam int MD_CYCLES = 4;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_LBU   = 32'h0040C283;
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;
    localparam logic [31:0] I_JALR1 = 32'h00009067;
    localparam logic [31:0] I_SD    = 32'h0020B023;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    ctrl_t           out_ctrl;
    logic            md_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_issue_queue #(
        .DEPTH     (DEPTH),
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_funct3 (out_funct3),
        .out_ctrl   (out_ctrl),
        .md_busy    (md_busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic ctrl_t mkCtrl(input logic rw, input logic mtr, input logic mr, input logic mw,
                                     input logic as, input logic br, input logic jmp, input logic au,
                                     input logic mu, input logic ill, input logic md,
                                     input logic [1:0] aop, input logic [1:0] isel, input logic [1:0] wid);
        ctrl_t c;
        c.reg_write    = rw;
        c.mem_to_reg   = mtr;
        c.mem_read     = mr;
        c.mem_write    = mw;
        c.alu_src      = as;
        c.branch       = br;
        c.jump         = jmp;
        c.auipc_sel    = au;
        c.mem_unsigned = mu;
        c.illegal      = ill;
        c.md           = md;
        c.alu_op       = alu_op_e'(aop);
        c.imm_sel      = imm_sel_e'(isel);
        c.mem_width    = mem_width_e'(wid);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle push; caller guarantees in_ready is high.
    task automatic applyStimulus(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic checkHead(input string tag, input ctrl_t exp_ctrl, input logic [XLEN-1:0] exp_pc);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_ctrl"}, 64'(out_ctrl), 64'(exp_ctrl));
        checkOutput({tag, "_pc"}, 64'(out_pc), 64'(exp_pc));
    endtask

    ctrl_t ill_ctrl;
    int    sent;
    int    idx;
    logic  accept;
    logic  fire_in;
    logic  fire_out;
    logic [XLEN-1:0] seen_pc;

    initial begin
        ill_ctrl  = mkCtrl(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        tick();
        tick();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
        checkOutput("rst_out_rd", 64'(out_rd), 64'd0);
        checkOutput("rst_md_busy", 64'(md_busy), 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ADD: no bypass in the push cycle, valid the next
        out_ready = 1'b1;
        in_instr  = I_ADD;
        in_pc     = 32'h100;
        in_valid  = 1'b1;
        #1;
        checkOutput("add_no_bypass", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        checkHead("add", mkCtrl(1,0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00), 32'h100);
        checkOutput("add_rd", 64'(out_rd), 64'd3);
        checkOutput("add_rs1", 64'(out_rs1), 64'd1);
        checkOutput("add_rs2", 64'(out_rs2), 64'd2);
        tick();
        checkOutput("add_popped", 64'(out_valid), 64'd0);

        applyStimulus(I_LBU, 32'h104);
        checkHead("lbu", mkCtrl(1,1,1,0,1,0,0,0,1,0,0,2'b00,2'b00,2'b00), 32'h104);
        checkOutput("lbu_rd", 64'(out_rd), 64'd5);
        checkOutput("lbu_funct3", 64'(out_funct3), 64'd4);
        tick();

        applyStimulus(I_SUB, 32'h108);
        checkHead("sub", mkCtrl(1,0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00), 32'h108);
        tick();

        applyStimulus(I_SD, 32'h10C);
        checkHead("store_f3_011", ill_ctrl, 32'h10C);
        tick();

        applyStimulus(I_ONES, 32'h110);
        checkHead("all_ones", ill_ctrl, 32'h110);
        tick();

        applyStimulus(I_JALR1, 32'h114);
        checkHead("jalr_f3_001", ill_ctrl, 32'h114);
        tick();

        // Back-pressure: three offers with out_ready low, then drain in order
        out_ready = 1'b0;
        in_instr  = I_ADD;
        in_pc     = '0;
        in_valid  = 1'b1;
        sent      = 0;
        for (int c = 0; c < 4; c++) begin
            accept = in_valid && in_ready;
            tick();
            if (accept) begin
                sent++;
                if (sent == 3) in_valid = 1'b0;
                else in_pc = XLEN'(sent * 4);
            end
        end
        checkOutput("bp_accepted", 64'(sent), 64'd2);
        checkOutput("bp_full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_head_pc", 64'(out_pc), 64'd0);
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            seen_pc  = out_pc;
            tick();
            if (fire_out) begin
                checkOutput("bp_order", 64'(seen_pc), 64'(idx * 4));
                idx++;
            end
            if (fire_in) begin
                sent++;
                if (sent == 3) in_valid = 1'b0;
                else in_pc = XLEN'(sent * 4);
            end
        end
        checkOutput("bp_issued_count", 64'(idx), 64'd3);
        in_valid = 1'b0;
        tick();

        // MUL: multi-cycle hold with the extension, trap entry without it
        out_ready = 1'b1;
        applyStimulus(I_MUL, 32'h200);
`ifdef DECODE_M_EXT_EN
        for (int k = 1; k < MD_CYCLES; k++) begin
            checkOutput("mul_hold_valid", 64'(out_valid), 64'd0);
            checkOutput("mul_md_busy", 64'(md_busy), 64'd1);
            tick();
        end
        checkHead("mul", mkCtrl(1,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), 32'h200);
        checkOutput("mul_busy_done", 64'(md_busy), 64'd0);
`else
        checkHead("mul_illegal", ill_ctrl, 32'h200);
        checkOutput("mul_md_busy", 64'(md_busy), 64'd0);
`endif
        tick();
        checkOutput("mul_popped", 64'(out_valid), 64'd0);

        // Flush with two queued entries and a third offered in the same cycle
        out_ready = 1'b0;
        applyStimulus(I_ADD, 32'h300);
        applyStimulus(I_ADD, 32'h304);
        checkOutput("pre_flush_valid", 64'(out_valid), 64'd1);
        checkOutput("pre_flush_in_ready", 64'(in_ready), 64'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = I_ADD;
        in_pc    = 32'h308;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        checkOutput("flush_md_busy", 64'(md_busy), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("flush_nothing_issued", 64'(out_valid), 64'd0);
        end

        // Reset mid-operation clears the queue and drops in_ready while asserted
        out_ready = 1'b0;
        applyStimulus(I_LBU, 32'h400);
        checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("mid_rst_ctrl", 64'(out_ctrl), 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("post_mid_rst_in_ready", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
